// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - register-hazard scoreboard with per-register pending-write counters
// Optional same-cycle release visibility: define SCOREBOARD_RELEASE_BYPASS_EN.
module scoreboard #(
    parameter int RFADDR = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RFADDR-1:0] query_1_i,
    input  logic [RFADDR-1:0] query_2_i,
    input  logic [RFADDR-1:0] commit_i,
    input  logic              release_valid_i,
    input  logic [RFADDR-1:0] release_addr_i,
    input  logic              flush_i,
    output logic              query_answer_1_o,
    output logic              query_answer_2_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int NREG = 1 << RFADDR;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry 0 is cleared by reset and never written again, so x0 always reads as idle.
    logic [CNT_W-1:0] r_cnt [NREG];
    logic             r_err;

    logic w_inc_en;
    logic w_dec_en;
    logic w_same;
    logic w_ovf;
    logic w_unf;
    logic w_busy_raw;
    logic w_ans_1_raw;
    logic w_ans_2_raw;

    assign w_inc_en = (commit_i != '0);
    assign w_dec_en = release_valid_i && (release_addr_i != '0);
    assign w_same   = w_inc_en && w_dec_en && (commit_i == release_addr_i);
    assign w_ovf    = w_inc_en && !w_same && (r_cnt[commit_i] == CNT_MAX);
    assign w_unf    = w_dec_en && !w_same && (r_cnt[release_addr_i] == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else if (flush_i) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            // A commit and release to the same register cancel; saturating ends only flag err.
            for (int r = 1; r < NREG; r++) begin
                if (w_inc_en && !w_same && (commit_i == RFADDR'(r)) && (r_cnt[r] != CNT_MAX)) begin
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                end else if (w_dec_en && !w_same && (release_addr_i == RFADDR'(r)) && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
                end
            end
            if (w_ovf || w_unf) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_busy_raw = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (r_cnt[r] != '0) begin
                w_busy_raw = 1'b1;
            end
        end
    end

    assign w_ans_1_raw = (query_1_i != '0) && (r_cnt[query_1_i] != '0);
    assign w_ans_2_raw = (query_2_i != '0) && (r_cnt[query_2_i] != '0);

`ifdef SCOREBOARD_RELEASE_BYPASS_EN
    logic w_byp_1;
    logic w_byp_2;
    logic w_busy_other;
    logic w_last_release;

    assign w_byp_1 = release_valid_i && (release_addr_i == query_1_i) && (query_1_i != '0)
                     && (r_cnt[query_1_i] == CNT_ONE);
    assign w_byp_2 = release_valid_i && (release_addr_i == query_2_i) && (query_2_i != '0)
                     && (r_cnt[query_2_i] == CNT_ONE);

    // Pending writes on registers other than the one being released this cycle.
    always_comb begin
        w_busy_other = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if ((RFADDR'(r) != release_addr_i) && (r_cnt[r] != '0)) begin
                w_busy_other = 1'b1;
            end
        end
    end

    assign w_last_release   = w_dec_en && (r_cnt[release_addr_i] == CNT_ONE) && !w_busy_other;
    assign query_answer_1_o = w_ans_1_raw && !w_byp_1;
    assign query_answer_2_o = w_ans_2_raw && !w_byp_2;
    assign busy_o           = w_busy_raw && !w_last_release;
`else
    assign query_answer_1_o = w_ans_1_raw;
    assign query_answer_2_o = w_ans_2_raw;
    assign busy_o           = w_busy_raw;
`endif

    assign err_o = r_err;

endmodule

// File: doc/scoreboard.md
# scoreboard

Register-hazard scoreboard for the imhotep core. It is the responder side of the decoder's scoreboard interface. Each cycle it answers the decoder's two source-register queries with "write pending" flags. It records a new pending write when the decoder commits a destination register, and retires that write when writeback releases it. The decoder's stall is the OR of the two answers, so answers are combinational from the registered state and have zero latency.

## Interface
Parameters:
- RFADDR, 5, register address width; the block tracks 2**RFADDR registers.
- CNT_W, 2, width of each per-register pending-write counter; maximum in-flight writes per register is 2**CNT_W-1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- query_1_i  input  RFADDR  source register 1 from decoder.
- query_2_i  input  RFADDR  source register 2 from decoder.
- commit_i  input  RFADDR  destination register issued this cycle; 0 means no commit.
- release_valid_i  input  1  writeback retires a write this cycle.
- release_addr_i  input  RFADDR  register being retired.
- flush_i  input  1  pipeline flush; discards all pending writes.
- query_answer_1_o  output  1  register query_1_i has a pending write.
- query_answer_2_o  output  1  register query_2_i has a pending write.
- busy_o  output  1  at least one register has a pending write (drain/fence indication).
- err_o  output  1  sticky flag for counter overflow or underflow.

## Operation
- State:
  - one CNT_W-bit counter per register, cnt[r];
  - the sticky err flag.
  - cnt[0] is constant 0 and is never stored.
- Answers:
  - query_answer_k_o = (cnt[query_k_i] != 0);
  - a query of x0 always answers 0.
- busy_o = OR over all cnt[r] != 0.
- Per-cycle update, evaluated in priority order:
  - flush_i=1: all counters become 0 next cycle. Commit and release in the same cycle are ignored. err is unchanged.
  - Otherwise, let inc = (commit_i != 0) for register commit_i, and dec = release_valid_i && release_addr_i != 0 for register release_addr_i.
  - Same register with both inc and dec: counter unchanged.
  - Different registers: each is updated independently (+1 / -1).
  - Release with release_addr_i = 0: ignored, no error.
- Saturation:
  - Increment at 2**CNT_W-1: counter holds at max and err is set.
  - Decrement at 0: counter holds at 0 and err is set.
  - err stays set until rst_i; flush_i does not clear it.
- No handshake back-pressure: commit and release are single-cycle pulses, accepted unconditionally.

## Timing
- Reset values:
  - all counters 0;
  - query_answer_1_o = 0, query_answer_2_o = 0;
  - busy_o = 0, err_o = 0.
- Query-to-answer: combinational, 0 cycles.
- Commit at cycle N: the answer for that register is 1 from cycle N+1. A same-cycle query in N sees the pre-commit value.
- Release at cycle N: the counter decrements at the N+1 edge. See Configuration for same-cycle visibility.
- Flush at cycle N: all answers and busy_o are 0 from cycle N+1.
- rst_i asserted mid-operation: all state is cleared at the next edge, regardless of commit, release or flush.

## Configuration
- Macro: SCOREBOARD_RELEASE_BYPASS_EN.
- Defined: a same-cycle release is visible to queries. query_answer_k_o is forced to 0 when all of the following hold:
  - release_valid_i = 1;
  - release_addr_i = query_k_i != 0;
  - cnt[query_k_i] == 1.
  - busy_o is bypassed likewise when that release retires the last pending write.
  - This removes one stall cycle when writeback and the register file write happen in the same cycle.
- Undefined: answers and busy_o reflect registered counters only. The release becomes visible at N+1.

## Test plan
- Reset, then query x5/x6 with nothing pending -> answers 0/0, busy_o 0, err_o 0.
- Commit x5 at cycle 1 and query x5 at cycle 1 -> answer 0. Query x5 at cycle 2 -> answer 1, busy_o 1. Release x5 at cycle 3:
  - with bypass, answer 0 in cycle 3;
  - without bypass, answer 1 in cycle 3 and 0 in cycle 4.
- Commit x7 three times (CNT_W=2), then a fourth time -> count holds at 3 and err_o 1. Three releases -> answer 0, and err_o remains 1.
- Commit x8 and release x8 in the same cycle while cnt[x8]=1 -> cnt stays 1 and the answer stays 1. Commit x0 or release x0 -> no state change, no error.
- With x3, x9 and x31 pending, assert flush_i together with commit x4 -> next cycle all answers are 0 and busy_o 0. x4 is not pending.
- Release x10 at count 0 -> err_o 1 next cycle and the counter stays 0. Assert rst_i -> err_o 0 next cycle.
